// File: rtl/text_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// text_buffer -- VGA text-terminal cell store: cursor writes, CR/BS/wrap,
// rotating-top scroll and full clear, with a pixel-addressed read port.
// rev 1.0
// ----------------------------------------------------------------------------
module text_buffer #(
  parameter int COLS   = 71,
  parameter int ROWS   = 30,
  parameter int CHAR_W = 9,
  parameter int CHAR_H = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        din,
  input  logic                     clr,
  output logic                     ready,
  input  logic [9:0]               h_addr,
  input  logic [9:0]               v_addr,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(COLS)-1:0]  cur_col,
  output logic [$clog2(ROWS)-1:0]  cur_row
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [RW:0]        ROWS_X  = (RW+1)'(ROWS);
  localparam logic [DATA_W-1:0]  BLANK   = DATA_W'(8'h20);
  localparam logic [DATA_W-1:0]  CR_CODE = DATA_W'(8'h0D);
  localparam logic [DATA_W-1:0]  BS_CODE = DATA_W'(8'h08);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ALL = 2'd1,
    CLR_ROW = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [AW-1:0]     cnt, cnt_n;
  logic [CW-1:0]     col, col_n;
  logic [RW-1:0]     row, row_n;
  logic [RW-1:0]     top, top_n;
  logic              we;
  logic              advance;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  // Screen rows live in a ring: visible row r sits at physical (r+top) mod ROWS.
  function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] r, input logic [RW-1:0] t);
    logic [RW:0] s;
    s = {1'b0, r} + {1'b0, t};
    if (s >= ROWS_X) s = s - ROWS_X;
    return s[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] pr, input logic [CW-1:0] c);
    return AW'(pr) * AW'(COLS) + AW'(c);
  endfunction

  assign ready   = (state == IDLE);
  assign cur_col = col;
  assign cur_row = row;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state <= CLR_ALL;
      cnt   <= '0;
      col   <= '0;
      row   <= '0;
      top   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      col   <= col_n;
      row   <= row_n;
      top   <= top_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    col_n   = col;
    row_n   = row;
    top_n   = top;
    we      = 1'b0;
    advance = 1'b0;
    waddr   = cell_addr(phys_row(row, top), col);
    wdata   = din;
    case (state)
      IDLE: begin
        if (clr) begin
          state_n = CLR_ALL;
          cnt_n   = '0;
        end else if (wr_en) begin
          if (din == CR_CODE) begin
            col_n   = '0;
            advance = 1'b1;
          end else if (din == BS_CODE) begin
            if (col != '0) begin
              col_n = col - 1'b1;
              we    = 1'b1;
              wdata = BLANK;
              waddr = cell_addr(phys_row(row, top), col - 1'b1);
            end
          end else begin
            we = 1'b1;
            if (col == CW'(COLS-1)) begin
              col_n   = '0;
              advance = 1'b1;
            end else begin
              col_n = col + 1'b1;
            end
          end
        end
      end
      CLR_ALL: begin
        we    = 1'b1;
        wdata = BLANK;
        waddr = cnt;
        if (cnt == AW'(DEPTH-1)) begin
          state_n = IDLE;
          col_n   = '0;
          row_n   = '0;
          top_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      CLR_ROW: begin
        // top has already rotated, so visible row ROWS-1 is the recycled line
        we    = 1'b1;
        wdata = BLANK;
        waddr = cell_addr(phys_row(RW'(ROWS-1), top), cnt[CW-1:0]);
        if (cnt == AW'(COLS-1)) state_n = IDLE;
        else                    cnt_n   = cnt + 1'b1;
      end
      default: begin
        state_n = CLR_ALL;
        cnt_n   = '0;
      end
    endcase
    if (advance) begin
      if (row != RW'(ROWS-1)) begin
        row_n = row + 1'b1;
      end else begin
        top_n   = (top == RW'(ROWS-1)) ? '0 : top + 1'b1;
        state_n = CLR_ROW;
        cnt_n   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we && clrn) mem[waddr] <= wdata;
  end

  logic [9:0]    hc, vr;
  logic          rd_ok;
  logic [AW-1:0] rd_addr;

  assign hc      = h_addr / 10'(CHAR_W);
  assign vr      = v_addr / 10'(CHAR_H);
  assign rd_ok   = (hc < 10'(COLS)) && (vr < 10'(ROWS));
  assign rd_addr = cell_addr(phys_row(vr[RW-1:0], top), hc[CW-1:0]);

  always_ff @(posedge clk) begin
    if (!clrn)      dout <= '0;
    else if (rd_ok) dout <= mem[rd_addr];
    else            dout <= '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_text_buffer.sv
`default_nettype none
// tb_text_buffer -- scoreboard bench: a screen model in visible coordinates
// predicts every read; expectations queue on address drive, pop on dout.
module tb_text_buffer;

  localparam int COLS   = 71;
  localparam int ROWS   = 30;
  localparam int CHAR_W = 9;
  localparam int CHAR_H = 16;
  localparam int DATA_W = 8;
  localparam int CW     = $clog2(COLS);
  localparam int RW     = $clog2(ROWS);

  logic              clk    = 1'b0;
  logic              clrn   = 1'b0;
  logic              wr_en  = 1'b0;
  logic              clr    = 1'b0;
  logic [DATA_W-1:0] din    = '0;
  logic [9:0]        h_addr = '0;
  logic [9:0]        v_addr = '0;
  logic              ready;
  logic [DATA_W-1:0] dout;
  logic [CW-1:0]     cur_col;
  logic [RW-1:0]     cur_row;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] scr [ROWS][COLS];
  int                mcol, mrow;
  bit                scrolled;
  logic [DATA_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  text_buffer #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .clrn(clrn), .wr_en(wr_en), .din(din), .clr(clr), .ready(ready),
    .h_addr(h_addr), .v_addr(v_addr), .dout(dout), .cur_col(cur_col), .cur_row(cur_row)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n, input int limit);
    n = 0;
    while (ready !== 1'b1 && n < limit) begin
      n++;
      tick();
    end
  endtask

  task automatic model_blank();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        scr[r][c] = 8'h20;
    mcol = 0;
    mrow = 0;
  endtask

  task automatic model_advance();
    if (mrow < ROWS-1) begin
      mrow++;
    end else begin
      for (int r = 0; r < ROWS-1; r++)
        for (int c = 0; c < COLS; c++)
          scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h20;
      scrolled = 1'b1;
    end
  endtask

  task automatic model_byte(input logic [DATA_W-1:0] b);
    scrolled = 1'b0;
    if (b == 8'h0D) begin
      mcol = 0;
      model_advance();
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        scr[mrow][mcol] = 8'h20;
      end
    end else begin
      scr[mrow][mcol] = b;
      if (mcol == COLS-1) begin
        mcol = 0;
        model_advance();
      end else begin
        mcol++;
      end
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] b);
    int n;
    wait_ready(n, 3000);
    wr_en = 1'b1;
    din   = b;
    tick();
    wr_en = 1'b0;
    model_byte(b);
    wait_ready(n, 200);
    check("busy_cycles", n, scrolled ? COLS : 0);
    check("cur_col", cur_col, mcol);
    check("cur_row", cur_row, mrow);
  endtask

  task automatic read_px(input int h, input int v, input logic [DATA_W-1:0] exp, input string tag);
    h_addr = 10'(h);
    v_addr = 10'(v);
    exp_q.push_back(exp);
    tick();
    check(tag, dout, exp_q.pop_front());
  endtask

  task automatic scan(input int r0, input int r1);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < COLS; c++)
        read_px(c*CHAR_W + (r+c) % CHAR_W, r*CHAR_H + (3*r+c) % CHAR_H, scr[r][c],
                $sformatf("cell r%0d c%0d", r, c));
  endtask

  initial begin
    int n;
    // Reset state and initial full clear
    repeat (3) tick();
    check("rst_ready", ready, 0);
    check("rst_dout", dout, 0);
    check("rst_col", cur_col, 0);
    check("rst_row", cur_row, 0);
    clrn = 1'b1;
    model_blank();
    wait_ready(n, 3000);
    check("init_clear_cycles", n, ROWS*COLS);
    scan(0, ROWS-1);

    // Two characters and the one-cycle read latency
    send(8'h41);
    send(8'h42);
    read_px(0, 0, 8'h41, "read_A");
    read_px(9, 0, 8'h42, "read_B");

    // Back to column 0, then a full line wraps to row 1, CR to row 2
    send(8'h08);
    send(8'h08);
    for (int c = 0; c < COLS; c++) send(8'h78);
    send(8'h0D);
    scan(0, 2);

    // Backspace on row 3, including the no-op at column 0
    send(8'h0D);
    send(8'h51);
    send(8'h08);
    send(8'h08);
    scan(3, 3);

    // Fill to the bottom, CR on the last row scrolls; a wrap scrolls again
    for (int r = 3; r < ROWS; r++)
      for (int c = 0; c < ((r == ROWS-1) ? COLS-1 : COLS); c++)
        send(8'(8'h21 + (r*7 + c) % 90));
    send(8'h0D);
    scan(0, ROWS-1);
    for (int c = 0; c < COLS; c++) send(8'h2A);
    scan(0, ROWS-1);

    // Clean clear command
    wait_ready(n, 3000);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_blank();
    wait_ready(n, 3000);
    check("clr_cycles", n, ROWS*COLS);
    check("clr_col", cur_col, 0);
    check("clr_row", cur_row, 0);
    scan(0, 0);
    scan(ROWS-1, ROWS-1);

    // clr beats wr_en, writes while busy are dropped, reset restarts the clear
    send(8'h55);
    wait_ready(n, 3000);
    clr   = 1'b1;
    wr_en = 1'b1;
    din   = 8'h5A;
    tick();
    clr = 1'b0;
    check("clr_wr_busy", ready, 0);
    din = 8'h41;
    tick();
    wr_en = 1'b0;
    repeat (100) tick();
    clrn = 1'b0;
    tick();
    tick();
    check("rst2_ready", ready, 0);
    check("rst2_dout", dout, 0);
    clrn = 1'b1;
    model_blank();
    wait_ready(n, 3000);
    check("restart_clear_cycles", n, ROWS*COLS);
    check("restart_col", cur_col, 0);
    check("restart_row", cur_row, 0);
    scan(0, ROWS-1);

    // Pixels outside the text area read as zero
    read_px(700, 0, 8'h00, "oob_h700");
    read_px(COLS*CHAR_W, 0, 8'h00, "oob_h_edge");
    read_px(COLS*CHAR_W-1, 0, 8'h20, "last_col_px");
    read_px(0, ROWS*CHAR_H, 8'h00, "oob_v_edge");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
